// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive framer: FSM state encoding,
// the widest supported character, and a helper giving strobes per frame.
package uart_rx_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } rx_state_e;

   localparam int MAX_DATA_BITS = 9;

   // Start bit + data bits + optional parity bit + stop bits.
   function automatic int frame_len(input int dataBits, input int stopBits, input bit hasParity);
      return 1 + dataBits + (hasParity ? 1 : 0) + stopBits;
   endfunction

endpackage

// File: rtl/frame_bit_counter.sv
// Counts strobes within one framer state; tc_o pulses on the strobe that reaches
// TERM_COUNT, and the count wraps back to zero on that same strobe.
module frame_bit_counter #(
   parameter int TERM_COUNT = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic step_i,
   output logic tc_o
);

   localparam int W = (TERM_COUNT > 1) ? $clog2(TERM_COUNT) : 1;
   localparam logic [W-1:0] LAST = W'(TERM_COUNT - 1);

   logic [W-1:0] count_q;

   always_ff @(posedge clk) begin
      if (rst || clear_i) begin
         count_q <= '0;
      end else if (step_i) begin
         count_q <= (count_q == LAST) ? '0 : count_q + 1'b1;
      end
   end

   assign tc_o = step_i && (count_q == LAST);

endmodule

// File: rtl/uart_rx_framer.sv
// UART receive framer: assembles strobed line samples into characters with a
// valid/ready output hold and sticky overrun. Define PARITY_CHECK_EN to add a parity bit.
module uart_rx_framer
   import uart_rx_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 bit_strobe,
   input  logic                 rx_bit,
   input  logic                 char_ready,
   input  logic                 err_clr,
   output logic [DATA_BITS-1:0] char_data,
   output logic                 char_valid,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun,
   output logic                 busy
);

   if (DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS || STOP_BITS < 1 || STOP_BITS > 2 ||
       PARITY_ODD < 0 || PARITY_ODD > 1) begin : gBadParams
      $error("uart_rx_framer: parameter out of legal range");
   end

   rx_state_e            state_q;
   logic [DATA_BITS-1:0] shift_q;
   logic [DATA_BITS-1:0] charData_q;
   logic                 stopErr_q;
   logic                 charValid_q;
   logic                 frameErr_q;
   logic                 overrun_q;
   logic                 busy_q;
   logic                 dataTc;
   logic                 stopTc;
   logic                 handshake;
   logic                 frameErr_d;
   logic                 parityErr_d;

   frame_bit_counter #(.TERM_COUNT(DATA_BITS)) dataCnt (
      .clk     (clk),
      .rst     (rst),
      .clear_i (bit_strobe && (state_q == IDLE)),
      .step_i  (bit_strobe && (state_q == DATA)),
      .tc_o    (dataTc)
   );

   frame_bit_counter #(.TERM_COUNT(STOP_BITS)) stopCnt (
      .clk     (clk),
      .rst     (rst),
      .clear_i (bit_strobe && (state_q == IDLE)),
      .step_i  (bit_strobe && (state_q == STOP)),
      .tc_o    (stopTc)
   );

   assign handshake  = charValid_q && char_ready;
   assign frameErr_d = stopErr_q || !rx_bit;

`ifdef PARITY_CHECK_EN
   logic parityBit_q;
   logic parityErr_q;

   // Even parity: data plus parity bit has an even number of ones; odd flips the sense.
   assign parityErr_d = (^shift_q) ^ parityBit_q ^ PARITY_ODD[0];
   assign parity_err  = parityErr_q;
`else
   assign parityErr_d = 1'b0;
   assign parity_err  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         charData_q  <= '0;
         stopErr_q   <= 1'b0;
         charValid_q <= 1'b0;
         frameErr_q  <= 1'b0;
         overrun_q   <= 1'b0;
         busy_q      <= 1'b0;
`ifdef PARITY_CHECK_EN
         parityBit_q <= 1'b0;
         parityErr_q <= 1'b0;
`endif
      end else begin
         if (handshake) begin
            charValid_q <= 1'b0;
         end
         if (err_clr) begin
            overrun_q <= 1'b0;
         end
         if (bit_strobe) begin
            unique case (state_q)
               IDLE: begin
                  if (!rx_bit) begin
                     state_q   <= DATA;
                     busy_q    <= 1'b1;
                     stopErr_q <= 1'b0;
                  end
               end
               DATA: begin
                  shift_q <= {rx_bit, shift_q[DATA_BITS-1:1]};
                  if (dataTc) begin
`ifdef PARITY_CHECK_EN
                     state_q <= PARITY;
`else
                     state_q <= STOP;
`endif
                  end
               end
               PARITY: begin
`ifdef PARITY_CHECK_EN
                  parityBit_q <= rx_bit;
                  state_q     <= STOP;
`else
                  state_q     <= IDLE;
                  busy_q      <= 1'b0;
`endif
               end
               STOP: begin
                  stopErr_q <= frameErr_d;
                  if (stopTc) begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                     // A pending unconsumed character wins; the new one is dropped.
                     if (!charValid_q || handshake) begin
                        charValid_q <= 1'b1;
                        charData_q  <= shift_q;
                        frameErr_q  <= frameErr_d;
`ifdef PARITY_CHECK_EN
                        parityErr_q <= parityErr_d;
`endif
                     end else begin
                        overrun_q <= 1'b1;
                     end
                  end
               end
            endcase
         end
      end
   end

   assign char_data  = charData_q;
   assign char_valid = charValid_q;
   assign frame_err  = frameErr_q;
   assign overrun    = overrun_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed self-checking bench for uart_rx_framer; expected characters are queued
// as frames are driven and compared when the framer presents them.
module tb_uart_rx_framer;

   localparam int DATA_BITS  = 8;
   localparam int STOP_BITS  = 1;
   localparam int PARITY_ODD = 0;
`ifdef PARITY_CHECK_EN
   localparam bit HAS_PARITY = 1'b1;
`else
   localparam bit HAS_PARITY = 1'b0;
`endif

   typedef struct packed {
      logic [7:0] data;
      logic       ferr;
      logic       perr;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 bit_strobe = 1'b0;
   logic                 rx_bit = 1'b1;
   logic                 char_ready = 1'b0;
   logic                 err_clr = 1'b0;
   logic [DATA_BITS-1:0] char_data;
   logic                 char_valid;
   logic                 frame_err;
   logic                 parity_err;
   logic                 overrun;
   logic                 busy;

   exp_t expQ[$];
   int   tests = 0;
   int   fails = 0;

   uart_rx_framer #(
      .DATA_BITS  (DATA_BITS),
      .STOP_BITS  (STOP_BITS),
      .PARITY_ODD (PARITY_ODD)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bit_strobe (bit_strobe),
      .rx_bit     (rx_bit),
      .char_ready (char_ready),
      .err_clr    (err_clr),
      .char_data  (char_data),
      .char_valid (char_valid),
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .overrun    (overrun),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests++;
      assert (observed === expected) else begin
         fails++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   function automatic exp_t mkExp(input logic [7:0] data, input logic ferr, input logic parFlip);
      exp_t e;
      e.data = data;
      e.ferr = ferr;
      e.perr = HAS_PARITY ? parFlip : 1'b0;
      return e;
   endfunction

   task automatic driveBit(input logic v, input int gap);
      @(negedge clk);
      bit_strobe = 1'b1;
      rx_bit     = v;
      @(negedge clk);
      bit_strobe = 1'b0;
      rx_bit     = 1'b1;
      repeat (gap) @(negedge clk);
   endtask

   // Drives one frame LSB first; returns on the negedge after the final stop strobe.
   task automatic applyStimulus(input logic [7:0] data, input logic parFlip, input logic lastStop,
                                input int gap, input logic readyOnLast, input logic clrOnLast);
      driveBit(1'b0, gap);
      for (int i = 0; i < DATA_BITS; i++) driveBit(data[i], gap);
      if (HAS_PARITY) driveBit((^data) ^ PARITY_ODD[0] ^ parFlip, gap);
      for (int s = 0; s < STOP_BITS - 1; s++) driveBit(1'b1, gap);
      @(negedge clk);
      bit_strobe = 1'b1;
      rx_bit     = lastStop;
      char_ready = readyOnLast;
      err_clr    = clrOnLast;
      @(negedge clk);
      bit_strobe = 1'b0;
      rx_bit     = 1'b1;
      char_ready = 1'b0;
      err_clr    = 1'b0;
   endtask

   task automatic checkHead(input string tag);
      exp_t e;
      checkOutput({tag, "_queued"}, 32'(expQ.size() != 0), 32'd1);
      if (expQ.size() != 0) begin
         e = expQ[0];
         checkOutput({tag, "_valid"}, 32'(char_valid), 32'd1);
         checkOutput({tag, "_data"},  32'(char_data),  32'(e.data));
         checkOutput({tag, "_ferr"},  32'(frame_err),  32'(e.ferr));
         checkOutput({tag, "_perr"},  32'(parity_err), 32'(e.perr));
      end
   endtask

   task automatic consume(input string tag);
      exp_t e;
      @(negedge clk);
      char_ready = 1'b1;
      @(negedge clk);
      char_ready = 1'b0;
      if (expQ.size() != 0) e = expQ.pop_front();
      checkOutput({tag, "_drop"}, 32'(char_valid), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      exp_t dropped;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      checkOutput("rst_valid",   32'(char_valid), 32'd0);
      checkOutput("rst_data",    32'(char_data),  32'd0);
      checkOutput("rst_ferr",    32'(frame_err),  32'd0);
      checkOutput("rst_perr",    32'(parity_err), 32'd0);
      checkOutput("rst_overrun", 32'(overrun),    32'd0);
      checkOutput("rst_busy",    32'(busy),       32'd0);

      // False start bit leaves the framer idle.
      driveBit(1'b1, 0);
      checkOutput("false_start_busy", 32'(busy), 32'd0);

      // Good 0xA5 frame with idle gaps between strobes.
      expQ.push_back(mkExp(8'hA5, 1'b0, 1'b0));
      applyStimulus(8'hA5, 1'b0, 1'b1, 2, 1'b0, 1'b0);
      checkHead("a5");
      checkOutput("a5_busy_after", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      checkHead("a5_hold");
      consume("a5");

      // Bad stop bit still delivers the data.
      expQ.push_back(mkExp(8'hA5, 1'b1, 1'b0));
      applyStimulus(8'hA5, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      checkHead("ferr");
      consume("ferr");

      // Overrun: second character dropped while the first waits.
      expQ.push_back(mkExp(8'hA5, 1'b0, 1'b0));
      applyStimulus(8'hA5, 1'b0, 1'b1, 0, 1'b0, 1'b0);
      checkOutput("ovr_before", 32'(overrun), 32'd0);
      applyStimulus(8'h3C, 1'b0, 1'b1, 0, 1'b0, 1'b0);
      checkHead("ovr_keep");
      checkOutput("ovr_set", 32'(overrun), 32'd1);
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      checkOutput("ovr_clr", 32'(overrun), 32'd0);
      applyStimulus(8'h11, 1'b0, 1'b1, 0, 1'b0, 1'b1);
      checkOutput("ovr_set_wins", 32'(overrun), 32'd1);
      checkHead("ovr_keep2");
      consume("ovr");
      checkOutput("ovr_sticky", 32'(overrun), 32'd1);
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      checkOutput("ovr_clr2", 32'(overrun), 32'd0);

      // Completion coinciding with a handshake loads the new character.
      expQ.push_back(mkExp(8'h81, 1'b0, 1'b0));
      applyStimulus(8'h81, 1'b0, 1'b1, 0, 1'b0, 1'b0);
      checkHead("hs_first");
      expQ.push_back(mkExp(8'h7E, 1'b0, 1'b0));
      applyStimulus(8'h7E, 1'b0, 1'b1, 0, 1'b1, 1'b0);
      dropped = expQ.pop_front();
      checkHead("hs_second");
      checkOutput("hs_no_overrun", 32'(overrun), 32'd0);
      consume("hs");

      // Reset mid-frame abandons the partial character.
      driveBit(1'b0, 0);
      for (int i = 0; i < 3; i++) driveBit(1'b1, 0);
      checkOutput("mid_busy", 32'(busy), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("mid_rst_busy",  32'(busy),       32'd0);
      checkOutput("mid_rst_valid", 32'(char_valid), 32'd0);
      repeat (3) @(negedge clk);
      checkOutput("mid_rst_valid_late", 32'(char_valid), 32'd0);
      expQ.push_back(mkExp(8'h3C, 1'b0, 1'b0));
      applyStimulus(8'h3C, 1'b0, 1'b1, 1, 1'b0, 1'b0);
      checkHead("after_rst");
      consume("after_rst");

      if (HAS_PARITY) begin
         // 0x07 with parity bit 0 (flip) and 1 (correct) under even parity.
         expQ.push_back(mkExp(8'h07, 1'b0, 1'b1));
         applyStimulus(8'h07, 1'b1, 1'b1, 0, 1'b0, 1'b0);
         checkHead("par_bad");
         consume("par_bad");
         expQ.push_back(mkExp(8'h07, 1'b0, 1'b0));
         applyStimulus(8'h07, 1'b0, 1'b1, 0, 1'b0, 1'b0);
         checkHead("par_good");
         consume("par_good");
      end

      // Reset clears a held character and a set overrun.
      applyStimulus(8'hC3, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      applyStimulus(8'h5A, 1'b0, 1'b1, 0, 1'b0, 1'b0);
      checkOutput("pre_rst_overrun", 32'(overrun), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("final_rst_valid",   32'(char_valid), 32'd0);
      checkOutput("final_rst_data",    32'(char_data),  32'd0);
      checkOutput("final_rst_ferr",    32'(frame_err),  32'd0);
      checkOutput("final_rst_overrun", 32'(overrun),    32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
